keycode_uart_tx: RTL
====================

KEYCODE_UART_TX -- requirements
Module: keycode_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10417, clk cycles per UART bit (100 MHz / 9600 baud).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, keycode queue entries (power of two, >= 2).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port keycode  input  16  scan code from the PS/2 receiver, valid when oflag rises.
REQ-006 SHALL have port oflag  input  1  new-keycode flag from the receiver, possibly high for several cycles.
REQ-007 SHALL have port tx  output  1  UART serial line, 8N1, idle high.
REQ-008 SHALL have port busy  output  1  high while a message is in flight or the FIFO is non-empty.
REQ-009 SHALL have port overflow  output  1  one-cycle pulse when a keycode is dropped.

Function
REQ-010 SHALL register oflag and push keycode on its 0->1 transition only; a level held high SHALL produce exactly one push.
REQ-011 SHALL store pushed keycodes in a FIFO of FIFO_DEPTH entries, delivered in push order.
REQ-012 SHALL drop a push when the FIFO is full, pulse overflow for that cycle and leave FIFO contents unchanged.
REQ-013 SHALL accept a push while full when a pop occurs in the same cycle.
REQ-014 SHALL use the FSM states IDLE, LOAD, SEND, NEXT.
REQ-015 IDLE: tx=1; leave to LOAD when the FIFO is non-empty.
REQ-016 LOAD: pop one keycode into a 16-bit message register, clear byte index to 0, go to SEND.
REQ-017 SEND: serialize the current byte, then go to NEXT when the stop bit completes.
REQ-018 NEXT: increment byte index; if index was 5 go to IDLE (or LOAD when the FIFO is non-empty), else go to SEND.
REQ-019 SHALL send 6 bytes per message: hex digits of keycode[15:12], [11:8], [7:4], [3:0], then 0x0D, 0x0A.
REQ-020 SHALL encode nibble n as 0x30+n for 0-9 and 0x37+n for 10-15 (uppercase A-F).
REQ-021 SHALL frame each byte as start bit 0, data LSB first, stop bit 1, each bit exactly CLKS_PER_BIT cycles.
REQ-022 SHALL start the first start bit no more than 3 cycles after the oflag rising edge when idle with the FIFO empty.
REQ-023 SHALL leave an inter-byte gap of at most 2 cycles of tx=1 within a message.
REQ-024 SHALL hold busy high from the push cycle until the last stop bit of the last queued message completes.
REQ-025 SHALL use a bit-period counter of ceil(log2(CLKS_PER_BIT)) bits that wraps to 0 at CLKS_PER_BIT-1.

Reset
REQ-026 SHALL, on rst_n low at any time, immediately force tx=1, busy=0, overflow=0, FSM=IDLE, FIFO empty and all counters 0, aborting any frame in progress.
REQ-027 SHALL treat oflag already high when rst_n deasserts as no edge (edge register reset to 1).

Structure
REQ-028 SHALL place ASCII constants (CR=0x0D, LF=0x0A, digit/letter offsets) and the FSM state encoding in a shared package keycode_uart_pkg.
REQ-029 SHALL implement byte serialization in one sub-module uart_tx_byte (inputs start, data[7:0]; outputs tx, done pulse).
REQ-030 SHALL keep the FIFO and hex encoding inline in keycode_uart_tx.

Verification (CLKS_PER_BIT=4)
REQ-031 keycode=0x001C, 1-cycle oflag while idle -> tx bytes 0x30,0x30,0x31,0x43,0x0D,0x0A; busy low within 250 cycles.
REQ-032 keycode=0xABCD, oflag high 10 cycles -> exactly one message "ABCD\r\n"; overflow never pulses.
REQ-033 During a message, 5 oflag edges with codes 0x0001-0x0005 -> one overflow pulse on the 5th; messages for 0x0001-0x0004 follow in order.
REQ-034 rst_n low mid-data-bit of byte 2 -> tx=1 in the same cycle; after release no further bytes; busy=0.
REQ-035 Push when FIFO full in the same cycle LOAD pops -> push accepted, no overflow pulse, message later transmitted.
REQ-036 keycode=0xF01C (break code) -> "F01C\r\n", each bit exactly 4 cycles measured on tx.

Source files
------------

// File: rtl/keycode_uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// keycode_uart_pkg : ASCII constants and FSM encoding for keycode_uart_tx
// Rev 1.0
// ------------------------------------------------------------------
package keycode_uart_pkg;

  localparam logic [7:0] ASCII_CR        = 8'h0D;
  localparam logic [7:0] ASCII_LF        = 8'h0A;
  localparam logic [7:0] ASCII_DIGIT_OFS = 8'h30;
  localparam logic [7:0] ASCII_ALPHA_OFS = 8'h37;

  // Byte index of the trailing LF within a message
  localparam logic [2:0] LAST_BYTE_IDX   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_NEXT = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// uart_tx_byte : 8N1 serializer, one byte per start request
// Rev 1.0
// ------------------------------------------------------------------
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       STOP_IDX = 4'd9;

  logic             active_q, active_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             bit_end;

  assign bit_end = active_q && (cnt_q == CNT_LAST);

  // bit_idx names the bit currently on the line: 0 start, 1-8 data, 9 stop
  always_comb begin
    active_d  = active_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    if (!active_q) begin
      cnt_d = '0;
      if (start) begin
        active_d  = 1'b1;
        bit_idx_d = 4'd0;
        shift_d   = data;
        tx_d      = 1'b0;
      end
    end else if (bit_end) begin
      cnt_d = '0;
      if (bit_idx_q == STOP_IDX) begin
        active_d = 1'b0;
        tx_d     = 1'b1;
      end else begin
        bit_idx_d = bit_idx_q + 4'd1;
        if (bit_idx_q == 4'd8) begin
          tx_d = 1'b1;
        end else begin
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q  <= 1'b0;
      bit_idx_q <= 4'd0;
      cnt_q     <= '0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
    end else begin
      active_q  <= active_d;
      bit_idx_q <= bit_idx_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  assign tx   = tx_q;
  // Asserted in the last cycle of the stop bit so the next byte can start one cycle later
  assign done = bit_end && (bit_idx_q == STOP_IDX);

endmodule
`default_nettype wire

// File: rtl/keycode_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// keycode_uart_tx : queues PS/2 keycodes and sends each as "HHHH\r\n"
// Rev 1.0
// ------------------------------------------------------------------
module keycode_uart_tx #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] keycode,
  input  logic        oflag,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);

  import keycode_uart_pkg::*;

  localparam int               PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return ASCII_DIGIT_OFS + {4'h0, n};
    else           return ASCII_ALPHA_OFS + {4'h0, n};
  endfunction

  function automatic logic [7:0] msg_byte(input logic [15:0] msg, input logic [2:0] idx);
    case (idx)
      3'd0:    return hex_ascii(msg[15:12]);
      3'd1:    return hex_ascii(msg[11:8]);
      3'd2:    return hex_ascii(msg[7:4]);
      3'd3:    return hex_ascii(msg[3:0]);
      3'd4:    return ASCII_CR;
      default: return ASCII_LF;
    endcase
  endfunction

  logic             oflag_q;
  logic [15:0]      mem_q [FIFO_DEPTH];
  logic [15:0]      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [15:0]      msg_q, msg_d;

  logic             push_w, pop_w, full_w, push_ok_w;
  logic [15:0]      head_w;
  logic             start_w, byte_done_w;
  logic [7:0]       byte_w;

  assign push_w    = oflag && !oflag_q;
  assign full_w    = (count_q == FIFO_FULL);
  assign pop_w     = (state_q == ST_LOAD);
  // A pop in the same cycle frees the slot the write pointer aliases when full
  assign push_ok_w = push_w && (!full_w || pop_w);
  assign head_w    = mem_q[rd_ptr_q];

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = push_w && full_w && !pop_w;
    if (push_ok_w) begin
      mem_d[wr_ptr_q] = keycode;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_w) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok_w && !pop_w) begin
      count_d = count_q + (PTR_W+1)'(1);
    end else if (!push_ok_w && pop_w) begin
      count_d = count_q - (PTR_W+1)'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    msg_d   = msg_q;
    start_w = 1'b0;
    byte_w  = ASCII_LF;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        msg_d   = head_w;
        idx_d   = 3'd0;
        start_w = 1'b1;
        byte_w  = msg_byte(head_w, 3'd0);
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (byte_done_w) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        idx_d = idx_q + 3'd1;
        if (idx_q == LAST_BYTE_IDX) begin
          state_d = (count_q != '0) ? ST_LOAD : ST_IDLE;
        end else begin
          start_w = 1'b1;
          byte_w  = msg_byte(msg_q, idx_q + 3'd1);
          state_d = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Reset high so a flag already asserted at release is not taken as an edge
      oflag_q    <= 1'b1;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 16'h0000;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
      idx_q      <= 3'd0;
      msg_q      <= 16'h0000;
    end else begin
      oflag_q    <= oflag;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      msg_q      <= msg_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start_w),
    .data (byte_w),
    .tx   (tx),
    .done (byte_done_w)
  );

  assign busy     = push_w || (state_q != ST_IDLE) || (count_q != '0);
  assign overflow = overflow_q;

endmodule
`default_nettype wire
